// File: rtl/u_mcb_write_if.sv
// rtl/u_mcb_write_if.sv - MCB user-port write-side signal bundle
interface u_mcb_write_if;
    logic        test_en;
    logic        u_wr_full;
    logic        u_wr_cmd_done;
    logic        u_wr_en;
    logic [31:0] u_wr_data;
    logic [3:0]  u_wr_mask;
    logic        u_wr_cmd_en;
    logic [29:0] u_wr_addr;
    logic [6:0]  u_wr_len;
    logic        u_wr_busy;
    logic [15:0] u_wr_burst_cnt;

    // Traffic generator side: drives data, strobes and command.
    modport master (
        input  test_en,
        input  u_wr_full,
        input  u_wr_cmd_done,
        output u_wr_en,
        output u_wr_data,
        output u_wr_mask,
        output u_wr_cmd_en,
        output u_wr_addr,
        output u_wr_len,
        output u_wr_busy,
        output u_wr_burst_cnt
    );

    // MCB / control side: FIFO status, command acknowledge and enable.
    modport slave (
        output test_en,
        output u_wr_full,
        output u_wr_cmd_done,
        input  u_wr_en,
        input  u_wr_data,
        input  u_wr_mask,
        input  u_wr_cmd_en,
        input  u_wr_addr,
        input  u_wr_len,
        input  u_wr_busy,
        input  u_wr_burst_cnt
    );
endinterface

// File: rtl/u_mcb_write.sv
// rtl/u_mcb_write.sv - MCB write traffic generator: fill FIFO with pattern, issue one command per burst
module u_mcb_write #(
    parameter int unsigned BURST_LEN = 64,
    parameter logic [29:0] ADDR_INC  = 30'h400,
    parameter logic [29:0] END_ADDR  = 30'h0FFFFC00
) (
    input  logic          clk,
    input  logic          rst,
    u_mcb_write_if.master wr
);

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_FILL = 2'd1,
        WR_CMD  = 2'd2,
        WR_NEXT = 2'd3
    } wr_state_e;

    localparam logic [6:0]  LEN      = 7'(BURST_LEN);
    localparam logic [6:0]  LEN_LAST = 7'(BURST_LEN - 1);
    localparam logic [31:0] PAT_EVEN = 32'hAAAAAAAA;
    localparam logic [31:0] PAT_ODD  = 32'h55555555;

    wr_state_e   state_q, state_d;
    logic [6:0]  wcnt_q, wcnt_d;
    logic [29:0] addr_gen_q, addr_gen_d;
    logic [29:0] wr_addr_q, wr_addr_d;
    logic        cmd_en_q, cmd_en_d;
    logic [15:0] burst_cnt_q, burst_cnt_d;
    logic [6:0]  wr_len_q;

    logic        wr_en;
    logic [31:0] wr_data;
    logic        busy;
    logic        last_word;
    logic [29:0] addr_gen_inc;

    // The word accepted this cycle is the final one of the burst.
    assign last_word = wr_en && (wcnt_q == LEN_LAST);

    // Next burst start address, wrapping after the top burst slot.
    assign addr_gen_inc = (addr_gen_q == END_ADDR) ? 30'h0 : (addr_gen_q + ADDR_INC);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; test_en is only looked at in IDLE and NEXT so bursts always finish.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WR_IDLE: begin
                if (wr.test_en) begin
                    state_d = WR_FILL;
                end
            end
            WR_FILL: begin
                if (last_word || (wcnt_q >= LEN)) begin
                    state_d = WR_CMD;
                end
            end
            WR_CMD: begin
                if (wr.u_wr_cmd_done) begin
                    state_d = WR_NEXT;
                end
            end
            WR_NEXT: begin
                state_d = wr.test_en ? WR_FILL : WR_IDLE;
            end
            default: state_d = WR_IDLE;
        endcase
    end

    // FSM outputs: data strobe, pattern word and busy flag.
    always_comb begin
        wr_en   = (state_q == WR_FILL) && !wr.u_wr_full && (wcnt_q < LEN);
        wr_data = wcnt_q[0] ? PAT_ODD : PAT_EVEN;
        busy    = (state_q != WR_IDLE);
    end

    // Datapath next-state: word counter, address generator, command and burst count.
    always_comb begin
        wcnt_d      = wcnt_q;
        addr_gen_d  = addr_gen_q;
        wr_addr_d   = wr_addr_q;
        cmd_en_d    = cmd_en_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            WR_IDLE: begin
                if (wr.test_en) begin
                    wr_addr_d = addr_gen_q;
                    wcnt_d    = 7'd0;
                end
            end
            WR_FILL: begin
                if (wr_en) begin
                    wcnt_d = wcnt_q + 7'd1;
                end
                if (state_d == WR_CMD) begin
                    cmd_en_d = 1'b1;
                end
            end
            WR_CMD: begin
                if (wr.u_wr_cmd_done) begin
                    cmd_en_d = 1'b0;
                end
            end
            WR_NEXT: begin
                burst_cnt_d = burst_cnt_q + 16'd1;
                addr_gen_d  = addr_gen_inc;
                if (wr.test_en) begin
                    wr_addr_d = addr_gen_inc;
                    wcnt_d    = 7'd0;
                end
            end
            default: begin
                cmd_en_d = 1'b0;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q      <= 7'd0;
            addr_gen_q  <= 30'h0;
            wr_addr_q   <= 30'h0;
            cmd_en_q    <= 1'b0;
            burst_cnt_q <= 16'd0;
            wr_len_q    <= LEN;
        end else begin
            wcnt_q      <= wcnt_d;
            addr_gen_q  <= addr_gen_d;
            wr_addr_q   <= wr_addr_d;
            cmd_en_q    <= cmd_en_d;
            burst_cnt_q <= burst_cnt_d;
            wr_len_q    <= LEN;
        end
    end

    assign wr.u_wr_en        = wr_en;
    assign wr.u_wr_data      = wr_data;
    assign wr.u_wr_mask      = 4'h0;
    assign wr.u_wr_cmd_en    = cmd_en_q;
    assign wr.u_wr_addr      = wr_addr_q;
    assign wr.u_wr_len       = wr_len_q;
    assign wr.u_wr_busy      = busy;
    assign wr.u_wr_burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_u_mcb_write.sv
// tb/tb_u_mcb_write.sv - scoreboard bench for u_mcb_write
module tb_u_mcb_write;
    localparam int BL = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    u_mcb_write_if mif ();

    u_mcb_write #(.BURST_LEN(BL)) dut (
        .clk (clk),
        .rst (rst),
        .wr  (mif)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q [$];
    logic [29:0] cmd_q [$];

    logic resp_done  = 1'b0;
    logic spur_done  = 1'b0;
    int   done_delay = 2;
    int   resp_cnt   = 0;
    assign mif.u_wr_cmd_done = resp_done | spur_done;

    int          word_idx = 0;
    logic [31:0] cap [0:BL-1];
    logic        prev_en = 1'b0, prev_cmd = 1'b0, prev_done = 1'b0;
    logic [29:0] prev_addr = '0;
    logic [6:0]  prev_len = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_burst(input logic [29:0] a);
        for (int i = 0; i < BL; i++) begin
            exp_q.push_back(i[0] ? 32'h55555555 : 32'hAAAAAAAA);
        end
        cmd_q.push_back(a);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_words(input int n, input string tag);
        int i;
        i = 0;
        while (word_idx < n && i < 3000) begin step(); i++; end
        chk(tag, 64'(word_idx >= n), 64'd1);
    endtask

    task automatic wait_cmd(input string tag);
        int i;
        i = 0;
        while (!mif.u_wr_cmd_en && i < 3000) begin step(); i++; end
        chk(tag, 64'(mif.u_wr_cmd_en), 64'd1);
    endtask

    task automatic wait_cnt(input logic [15:0] n, input string tag);
        int i;
        i = 0;
        while (mif.u_wr_burst_cnt !== n && i < 3000) begin step(); i++; end
        chk(tag, 64'(mif.u_wr_burst_cnt), 64'(n));
    endtask

    task automatic wait_idle(input string tag);
        int i;
        i = 0;
        while (mif.u_wr_busy && i < 3000) begin step(); i++; end
        chk(tag, 64'(mif.u_wr_busy), 64'd0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_wr_en"}, 64'(mif.u_wr_en), 64'd0);
        chk({tag, "_cmd_en"}, 64'(mif.u_wr_cmd_en), 64'd0);
        chk({tag, "_addr"}, 64'(mif.u_wr_addr), 64'd0);
        chk({tag, "_len"}, 64'(mif.u_wr_len), 64'(BL));
        chk({tag, "_busy"}, 64'(mif.u_wr_busy), 64'd0);
        chk({tag, "_cnt"}, 64'(mif.u_wr_burst_cnt), 64'd0);
        chk({tag, "_mask"}, 64'(mif.u_wr_mask), 64'd0);
    endtask

    // Command responder: acknowledge done_delay cycles after cmd_en rises.
    always @(posedge clk) begin
        #1;
        if (mif.u_wr_cmd_en) begin
            resp_cnt++;
            resp_done = (resp_cnt == done_delay);
        end else begin
            resp_cnt  = 0;
            resp_done = 1'b0;
        end
    end

    // Monitor: pop expected words/commands as the DUT produces them.
    always @(negedge clk) begin
        if (rst) begin
            word_idx  = 0;
            prev_en   = 1'b0;
            prev_cmd  = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (mif.u_wr_en) begin
                if (exp_q.size() == 0) chk("extra_word", 64'd1, 64'd0);
                else chk("wdata", 64'(mif.u_wr_data), 64'(exp_q.pop_front()));
                if (word_idx < BL) cap[word_idx] = mif.u_wr_data;
                word_idx++;
            end
            if (mif.u_wr_cmd_en && !prev_cmd) begin
                chk("words_per_burst", 64'(word_idx), 64'(BL));
                chk("cmd_after_last_word", 64'(prev_en), 64'd1);
                if (cmd_q.size() == 0) chk("extra_cmd", 64'd1, 64'd0);
                else chk("cmd_addr", 64'(mif.u_wr_addr), 64'(cmd_q.pop_front()));
                chk("cmd_len", 64'(mif.u_wr_len), 64'(BL));
                word_idx = 0;
            end
            if (prev_cmd) begin
                chk("cmd_fall_on_done", 64'(mif.u_wr_cmd_en), 64'(!prev_done));
                if (mif.u_wr_cmd_en) begin
                    chk("cmd_addr_stable", 64'(mif.u_wr_addr), 64'(prev_addr));
                    chk("cmd_len_stable", 64'(mif.u_wr_len), 64'(prev_len));
                    chk("no_wr_in_cmd", 64'(mif.u_wr_en), 64'd0);
                end
            end
            prev_en   = mif.u_wr_en;
            prev_cmd  = mif.u_wr_cmd_en;
            prev_done = mif.u_wr_cmd_done;
            prev_addr = mif.u_wr_addr;
            prev_len  = mif.u_wr_len;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        mif.test_en = 1'b0;
        mif.u_wr_full = 1'b0;
        repeat (3) step();
        chk_reset_state("rst");
        rst = 1'b0;
        step();

        // Back-to-back bursts at 0 and 0x400, then stop.
        push_burst(30'h0);
        push_burst(30'h400);
        mif.test_en = 1'b1;
        step();
        chk("first_busy", 64'(mif.u_wr_busy), 64'd1);
        chk("first_wr_en", 64'(mif.u_wr_en), 64'd1);
        chk("first_data", 64'(mif.u_wr_data), 64'hAAAAAAAA);
        wait_cmd("tmo_cmd1");
        @(negedge clk);
        #1;
        chk("word63", 64'(cap[63]), 64'h55555555);
        wait_cnt(16'd1, "burst_cnt1");
        chk("next_addr", 64'(mif.u_wr_addr), 64'h400);
        mif.test_en = 1'b0;
        wait_cnt(16'd2, "burst_cnt2");
        wait_idle("idle_t1");

        // FIFO-full stalls, then drop test_en at word 20 of the following burst.
        push_burst(30'h800);
        push_burst(30'hC00);
        mif.test_en = 1'b1;
        wait_words(10, "tmo_w10");
        mif.u_wr_full = 1'b1;
        #1;
        chk("full_stall", 64'(mif.u_wr_en), 64'd0);
        repeat (5) step();
        mif.u_wr_full = 1'b0;
        wait_words(40, "tmo_w40");
        mif.u_wr_full = 1'b1;
        repeat (3) step();
        mif.u_wr_full = 1'b0;
        wait_cmd("tmo_cmd3");
        @(negedge clk);
        #1;
        chk("word10", 64'(cap[10]), 64'hAAAAAAAA);
        chk("word41", 64'(cap[41]), 64'h55555555);
        wait_words(20, "tmo_w20");
        mif.test_en = 1'b0;
        wait_cnt(16'd4, "burst_cnt4");
        wait_idle("idle_t5");
        repeat (20) step();
        chk("t5_no_more_words", 64'(exp_q.size()), 64'd0);
        chk("t5_no_more_cmds", 64'(cmd_q.size()), 64'd0);
        chk("t5_wr_en_idle", 64'(mif.u_wr_en), 64'd0);

        // Long command stall.
        done_delay = 50;
        push_burst(30'h1000);
        mif.test_en = 1'b1;
        wait_words(5, "tmo_w5");
        mif.test_en = 1'b0;
        wait_cmd("tmo_cmd_stall");
        repeat (45) step();
        chk("stall_cmd_en", 64'(mif.u_wr_cmd_en), 64'd1);
        chk("stall_addr", 64'(mif.u_wr_addr), 64'h1000);
        chk("stall_wr_en", 64'(mif.u_wr_en), 64'd0);
        wait_cnt(16'd5, "burst_cnt5");
        wait_idle("idle_t3");
        chk("stall_cmd_dropped", 64'(mif.u_wr_cmd_en), 64'd0);
        done_delay = 2;

        // Address wrap at the top of the space.
        force dut.addr_gen_q = 30'h0FFFF800;
        step();
        release dut.addr_gen_q;
        step();
        push_burst(30'h0FFFF800);
        push_burst(30'h0FFFFC00);
        push_burst(30'h0);
        mif.test_en = 1'b1;
        step();
        chk("top_addr", 64'(mif.u_wr_addr), 64'h0FFFF800);
        wait_cnt(16'd7, "burst_cnt7");
        chk("wrap_addr", 64'(mif.u_wr_addr), 64'h0);
        mif.test_en = 1'b0;
        wait_cnt(16'd8, "burst_cnt8");
        wait_idle("idle_t4");

        // Spurious cmd_done in FILL, then reset mid-burst.
        push_burst(30'h400);
        mif.test_en = 1'b1;
        wait_words(5, "tmo_w5b");
        spur_done = 1'b1;
        step();
        spur_done = 1'b0;
        step();
        chk("spur_cmd_en", 64'(mif.u_wr_cmd_en), 64'd0);
        chk("spur_busy", 64'(mif.u_wr_busy), 64'd1);
        wait_words(30, "tmo_w30");
        rst = 1'b1;
        mif.test_en = 1'b0;
        step();
        step();
        chk_reset_state("midrst");
        exp_q.delete();
        cmd_q.delete();
        rst = 1'b0;
        step();
        push_burst(30'h0);
        mif.test_en = 1'b1;
        step();
        chk("restart_addr", 64'(mif.u_wr_addr), 64'h0);
        chk("restart_data", 64'(mif.u_wr_data), 64'hAAAAAAAA);
        wait_cmd("tmo_cmd_restart");
        mif.test_en = 1'b0;
        wait_cnt(16'd1, "restart_cnt");
        wait_idle("idle_t6");
        chk("end_words_drained", 64'(exp_q.size()), 64'd0);
        chk("end_cmds_drained", 64'(cmd_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/u_mcb_write.md
Name: u_mcb_write

Overview:
User-port write-side traffic generator for the DDR3 MCB test. It fills the MCB write FIFO with a fixed alternating pattern, then issues one write command per burst and advances through the address space. The pattern is 32'hAAAAAAAA on even words and 32'h55555555 on odd words. It is the producer that the MCB read-checker pairs with, so every burst it writes can be read back and compared.

Parameters:
BURST_LEN, 64, words per burst; legal range 1..64; driven on u_wr_len.
ADDR_INC, 30'h400, byte-address increment applied after each completed burst.
END_ADDR, 30'h0FFFFC00, last burst start address; the address after it wraps to 0.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst  in  1  synchronous reset, active-high.
test_en  in  1  high = generate bursts continuously; low = stop after the current burst.
u_wr_full  in  1  MCB write FIFO full; a word is accepted only when this is low.
u_wr_cmd_done  in  1  one-cycle pulse: MCB has accepted the write command.
u_wr_en  out  1  write-data strobe (combinational, see Behaviour).
u_wr_data  out  32  write data word.
u_wr_mask  out  4  byte mask; constant 4'h0.
u_wr_cmd_en  out  1  write command request, held until accepted.
u_wr_addr  out  30  burst start byte address; registered.
u_wr_len  out  7  burst length in words; registered.
u_wr_busy  out  1  high whenever the state is not WR_IDLE.
u_wr_burst_cnt  out  16  completed-burst counter; wraps modulo 2^16.

Behaviour:
- Reset: state WR_IDLE, u_wr_cmd_en=0, u_wr_addr=0, u_wr_len=BURST_LEN, word counter=0, address generator=0, u_wr_burst_cnt=0, u_wr_busy=0. u_wr_en=0 because the state is WR_IDLE. Reset mid-burst abandons the burst; no command is issued.
- States: WR_IDLE, WR_FILL, WR_CMD, WR_NEXT.
- WR_IDLE: if test_en=1, go to WR_FILL next cycle. On entry, load u_wr_addr from the address generator and clear the word counter.
- WR_FILL:
  - u_wr_en = (state==WR_FILL) && ~u_wr_full && (wcnt < BURST_LEN).
  - A word is transferred on each cycle with u_wr_en=1; wcnt then increments.
  - u_wr_data = wcnt[0] ? 32'h55555555 : 32'hAAAAAAAA (combinational from wcnt).
  - When wcnt==BURST_LEN, go to WR_CMD. u_wr_cmd_en rises on the first WR_CMD cycle, i.e. exactly one cycle after the last accepted word.
- WR_CMD:
  - u_wr_cmd_en=1 and u_wr_addr, u_wr_len held stable until u_wr_cmd_done=1.
  - On that edge, clear u_wr_cmd_en and go to WR_NEXT.
  - u_wr_cmd_done in any other state is ignored.
- WR_NEXT (one cycle):
  - u_wr_burst_cnt += 1.
  - Address generator: if addr_gen == END_ADDR then 0, else addr_gen + ADDR_INC.
  - Go to WR_FILL if test_en=1 (reload u_wr_addr, clear wcnt), else go to WR_IDLE.
- test_en falling while in WR_FILL or WR_CMD has no effect until WR_NEXT. Partial bursts are never left in the FIFO without a command.
- u_wr_full=1 for any number of cycles stalls WR_FILL. No word is skipped or repeated, and the pattern parity follows wcnt, not time.
- Address arithmetic: 30-bit unsigned, no overflow past END_ADDR.
- Minimum burst time with no backpressure: 1 (IDLE) + BURST_LEN (FILL) + ≥1 (CMD) + 1 (NEXT) cycles.

Test Plan:
1. Reset, then test_en=1 with u_wr_full=0 and cmd_done returned 2 cycles after cmd_en rises -> 64 u_wr_en pulses; data AAAAAAAA,55555555,… (word 63 = 55555555); u_wr_cmd_en high one cycle after the last word with u_wr_addr=0, u_wr_len=64; u_wr_burst_cnt=1; next burst at u_wr_addr=30'h400.
2. Assert u_wr_full for 5 cycles at word 10 and 3 cycles at word 40 -> exactly 64 writes, no duplicated or missing pattern word, word 10 = AAAAAAAA, word 41 = 55555555.
3. Hold cmd_done low for 50 cycles in WR_CMD -> u_wr_cmd_en stays 1, address and length stable, no further u_wr_en pulses; release -> cmd_en drops on the pulse edge.
4. Preload the generator near the top of the address space (run, or force to END_ADDR-ADDR_INC) -> burst start addresses go 30'h0FFFF800, 30'h0FFFFC00, then 30'h00000000.
5. Drop test_en at word 20 -> the burst completes (64 words plus command), u_wr_burst_cnt increments, the block returns to WR_IDLE with u_wr_busy=0, and no further writes occur.
6. Pulse cmd_done during WR_FILL, and assert rst at word 30 -> the spurious cmd_done is ignored; reset returns all outputs to their reset values, and the next test_en starts again at address 0 with AAAAAAAA.
